branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits (>=2).
REQ-002 Parameter PC_WIDTH, default 32, program-counter width in bits.
REQ-003 Parameter BHT_BITS, default 4; history table has 2^BHT_BITS entries.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  branch request present.
REQ-007 in_ready  output  1  unit can accept the request this cycle.
REQ-008 branch_type  input  3  000 beq, 001 bne, 010 bgt, 011 blt, 100 bge, 101 ble, 110 bgtu, 111 bleu.
REQ-009 op_a, op_b  input  WIDTH  compare operands.
REQ-010 pc_in  input  PC_WIDTH  address of the branch instruction.
REQ-011 offset  input  16  signed word offset.
REQ-012 pred_taken_in  input  1  prediction the front end used for this branch.
REQ-013 out_valid  output  1  resolved result held in output register.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 taken, mispredict  output  1 each  resolved direction; taken != pred_taken_in.
REQ-016 redirect_pc  output  PC_WIDTH  correct next PC.
REQ-017 lookup_pc  input  PC_WIDTH; lookup_taken  output  1  front-end prediction port.
REQ-018 mispredict_count  output  16  count of resolved mispredicts.

Function
REQ-019 Accept occurs when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-020 Latency one cycle: result of an accept appears registered in the next cycle with out_valid=1.
REQ-021 Output register holds all outputs stable while out_valid && !out_ready.
REQ-022 out_valid clears on a cycle with out_ready=1 and no accept; accept with out_ready=1 replaces result back-to-back without a bubble.
REQ-023 Signed compares (bgt/blt/bge/ble) use two's-complement WIDTH-bit values; bgtu/bleu unsigned; beq/bne bitwise equality.
REQ-024 Comparison is exact for all operand values, including most-negative and all-ones; no reliance on a subtract overflow flag.
REQ-025 Target = pc_in + 4 + (sign-extended offset << 2), modulo 2^PC_WIDTH (wraps silently).
REQ-026 redirect_pc = taken ? target : pc_in + 4, modulo 2^PC_WIDTH.
REQ-027 BHT: 2-bit saturating counters indexed by pc[BHT_BITS+1:2].
REQ-028 On accept, entry for pc_in increments if taken (saturate 11), else decrements (saturate 00).
REQ-029 lookup_taken = bit[1] of entry indexed by lookup_pc, combinational from current table contents.
REQ-030 Lookup and update to the same index in one cycle: lookup returns the pre-update value.
REQ-031 mispredict_count increments by 1 per accepted mispredict, saturates at 16'hFFFF.
REQ-032 No state changes when in_valid=0 or in_ready=0, except out_valid clearing per REQ-022.

Reset
REQ-033 rst=1 at a rising edge: out_valid=0, taken=0, mispredict=0, redirect_pc=0, mispredict_count=0, all BHT entries=01.
REQ-034 rst takes priority over a simultaneous accept; the request is dropped and not recorded.
REQ-035 in_ready=1 in the first cycle after reset deasserts.

Verification
REQ-036 WIDTH=32: bgt op_a=0x80000000 op_b=0x7FFFFFFF -> taken=0; bgtu same operands -> taken=1.
REQ-037 blt op_a=0xFFFFFFFF op_b=0 -> taken=1; bleu op_a=op_b=5 -> taken=1; bne equal -> taken=0.
REQ-038 beq equal, pc_in=0x100, offset=-2, pred_taken_in=0 -> next cycle out_valid=1, taken=1, redirect_pc=0xFC, mispredict=1, mispredict_count=1.
REQ-039 out_ready=0 for 3 cycles after a result -> outputs frozen, in_ready=0, BHT unchanged; out_ready=1 with new request -> next result in following cycle.
REQ-040 Three taken branches at pc=0x40 from reset -> entry 01->10->11->11; lookup_pc=0x40 during the first update cycle -> lookup_taken=0, afterwards 1.
REQ-041 rst asserted while out_valid=1 and in_valid=1 -> next cycle out_valid=0, count=0, entry for that pc=01.

Source files
------------

// File: rtl/branch_unit.sv
// branch_unit: one-cycle branch resolver (clk/rst; in_valid/in_ready/branch_type/op_a/op_b/pc_in/offset/pred_taken_in in; out_valid/out_ready/taken/mispredict/redirect_pc out; lookup_pc/lookup_taken BHT port; mispredict_count)
module branch_unit #(
  parameter int WIDTH = 32,
  parameter int PC_WIDTH = 32,
  parameter int BHT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          branch_type,
  input  logic [WIDTH-1:0]    op_a,
  input  logic [WIDTH-1:0]    op_b,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic [15:0]         offset,
  input  logic                pred_taken_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                taken,
  output logic                mispredict,
  output logic [PC_WIDTH-1:0] redirect_pc,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                lookup_taken,
  output logic [15:0]         mispredict_count
);
  logic accept, eq, lts, ltu, res;
  logic [PC_WIDTH-1:0] seq_pc, target;
  logic [BHT_BITS-1:0] idx;
  logic [1:0] bht [2**BHT_BITS];
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign eq = op_a == op_b;
  assign lts = $signed(op_a) < $signed(op_b);
  assign ltu = op_a < op_b;
  always_comb begin
    res = branch_type == 3'd0 ? eq :
          branch_type == 3'd1 ? !eq :
          branch_type == 3'd2 ? !lts && !eq :
          branch_type == 3'd3 ? lts :
          branch_type == 3'd4 ? !lts :
          branch_type == 3'd5 ? lts || eq :
          branch_type == 3'd6 ? !ltu && !eq : ltu || eq;
  end
  assign seq_pc = pc_in + PC_WIDTH'(4);
  assign target = seq_pc + PC_WIDTH'($signed({offset, 2'b00}));
  assign idx = pc_in[BHT_BITS+1:2];
  assign lookup_taken = bht[lookup_pc[BHT_BITS+1:2]][1];
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      taken <= 1'b0;
      mispredict <= 1'b0;
      redirect_pc <= '0;
      mispredict_count <= '0;
      for (int i = 0; i < 2**BHT_BITS; i++) bht[i] <= 2'b01;
    end else if (accept) begin
      out_valid <= 1'b1;
      taken <= res;
      mispredict <= res != pred_taken_in;
      redirect_pc <= res ? target : seq_pc;
      if (res && bht[idx] != 2'b11) bht[idx] <= bht[idx] + 2'd1;
      else if (!res && bht[idx] != 2'b00) bht[idx] <= bht[idx] - 2'd1;
      if (res != pred_taken_in && mispredict_count != 16'hFFFF) mispredict_count <= mispredict_count + 16'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: random and directed checks of branch_unit against a behavioural model
module tb_branch_unit;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, pred_taken_in = 1'b0;
  logic out_valid, out_ready = 1'b1, taken, mispredict, lookup_taken;
  logic [2:0] branch_type = '0;
  logic [31:0] op_a = '0, op_b = '0, pc_in = '0, redirect_pc, lookup_pc = '0;
  logic [15:0] offset = '0, mispredict_count;
  int checks = 0, errors = 0;
  bit m_valid, m_taken, m_mis, pre_lk;
  bit [31:0] m_redir;
  int m_cnt;
  int m_bht [16];

  branch_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .branch_type(branch_type), .op_a(op_a), .op_b(op_b), .pc_in(pc_in),
    .offset(offset), .pred_taken_in(pred_taken_in), .out_valid(out_valid),
    .out_ready(out_ready), .taken(taken), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_cond(input bit [2:0] t, input bit [31:0] a, input bit [31:0] b);
    longint sa = $signed(a), sb = $signed(b), ua = a, ub = b;
    case (t)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return sa > sb;
      3'd3: return sa < sb;
      3'd4: return sa >= sb;
      3'd5: return sa <= sb;
      3'd6: return ua > ub;
      default: return ua <= ub;
    endcase
  endfunction

  task automatic m_reset();
    m_valid = 0; m_taken = 0; m_mis = 0; m_redir = 0; m_cnt = 0;
    foreach (m_bht[i]) m_bht[i] = 1;
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic step(input bit r, input bit v, input bit [2:0] t, input bit [31:0] a, input bit [31:0] b,
                      input bit [31:0] pc, input bit [15:0] off, input bit p, input bit o, input bit [31:0] lp);
    bit acc, tk;
    longint so, tg;
    rst = r; in_valid = v; branch_type = t; op_a = a; op_b = b; pc_in = pc;
    offset = off; pred_taken_in = p; out_ready = o; lookup_pc = lp;
    #1;
    check("in_ready", in_ready, !m_valid || o);
    check("lookup_taken", lookup_taken, m_bht[lp[5:2]] >= 2);
    pre_lk = lookup_taken;
    acc = v && (!m_valid || o);
    if (r) m_reset();
    else if (acc) begin
      tk = m_cond(t, a, b);
      so = $signed(off);
      tg = longint'(pc) + 4 + (tk ? so * 4 : 0);
      m_valid = 1; m_taken = tk; m_mis = tk != p; m_redir = tg[31:0];
      m_bht[pc[5:2]] = tk ? (m_bht[pc[5:2]] < 3 ? m_bht[pc[5:2]] + 1 : 3) : (m_bht[pc[5:2]] > 0 ? m_bht[pc[5:2]] - 1 : 0);
      if (m_mis && m_cnt < 65535) m_cnt++;
    end else if (o) m_valid = 0;
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    check("taken", taken, m_taken);
    check("mispredict", mispredict, m_mis);
    check("redirect_pc", redirect_pc, m_redir);
    check("mispredict_count", mispredict_count, m_cnt);
  endtask

  function automatic bit [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      5: return $urandom_range(0, 7);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit [31:0] a;
    m_reset();
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40);
    check("reset_out_valid", out_valid, 0);
    check("reset_count", mispredict_count, 0);
    check("reset_redirect", redirect_pc, 0);
    check("reset_lookup", lookup_taken, 0);
    check("ready_after_reset", in_ready, 1);
    step(0, 1, 3'd0, 5, 5, 32'h100, 16'hFFFE, 0, 1, 0);
    check("beq_taken", taken, 1);
    check("beq_redirect", redirect_pc, 32'hFC);
    check("beq_mispredict", mispredict, 1);
    check("beq_count", mispredict_count, 1);
    step(0, 1, 3'd2, 32'h80000000, 32'h7FFFFFFF, 32'h200, 16'h0010, 0, 1, 0);
    check("bgt_min_vs_max", taken, 0);
    step(0, 1, 3'd6, 32'h80000000, 32'h7FFFFFFF, 32'h200, 16'h0010, 0, 1, 0);
    check("bgtu_min_vs_max", taken, 1);
    check("bgtu_redirect", redirect_pc, 32'h244);
    step(0, 1, 3'd3, 32'hFFFFFFFF, 0, 32'h300, 16'h0001, 1, 1, 0);
    check("blt_neg1_vs_0", taken, 1);
    step(0, 1, 3'd1, 32'h1234, 32'h1234, 32'h300, 16'h0001, 0, 1, 0);
    check("bne_equal", taken, 0);
    step(0, 1, 3'd7, 5, 5, 32'hFFFFFFFC, 16'h0001, 1, 1, 0);
    check("bleu_equal", taken, 1);
    check("target_wrap", redirect_pc, 32'h4);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd0, 1, 1, 32'h500, 0, 1, 0, 32'h500);
    check("stall_valid", out_valid, 1);
    check("stall_redirect", redirect_pc, 32'h4);
    check("stall_ready", in_ready, 0);
    step(0, 1, 3'd0, 1, 2, 32'h500, 0, 1, 1, 32'h500);
    check("after_stall_taken", taken, 0);
    check("after_stall_redirect", redirect_pc, 32'h504);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 3'd0, 3, 3, 32'h40, 16'h0004, 1, 1, 32'h40);
    check("bht_first_lookup", pre_lk, 0);
    step(0, 1, 3'd0, 3, 3, 32'h40, 16'h0004, 1, 1, 32'h40);
    check("bht_second_lookup", pre_lk, 1);
    step(0, 1, 3'd0, 3, 3, 32'h40, 16'h0004, 1, 1, 32'h40);
    step(0, 1, 3'd1, 3, 3, 32'h40, 16'h0004, 1, 1, 32'h40);
    check("bht_saturated_lookup", pre_lk, 1);
    check("bht_after_dec", lookup_taken, 1);
    step(1, 1, 3'd1, 3, 3, 32'h40, 16'h0004, 1, 1, 32'h40);
    check("rst_drop_valid", out_valid, 0);
    check("rst_drop_count", mispredict_count, 0);
    check("rst_drop_lookup", lookup_taken, 0);
    for (int n = 0; n < 3000; n++) begin
      a = pick();
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a,
           $urandom_range(0, 2) == 0 ? a : pick(), $urandom & 32'h3FC, 16'($urandom),
           1'($urandom), $urandom_range(0, 9) < 7, $urandom & 32'h3C);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
